// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory-wait freeze with timeout, branch shadow.
// Control outputs are combinational from state and inputs. Define HAZARD_PERF_EN to build the stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [3:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        BR_SHADOW = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       timeout_set;
    logic       stall_inc;
    logic       flush_inc;
    logic       load_use;

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt   = RUN;
        wait_nxt    = 8'd0;
        timeout_set = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (mem_busy) begin
            // Freeze the whole pipe; nothing is lost, the memory access just retries.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            stall_inc = 1'b1;
            if (state == MEM_WAIT) begin
                if (wait_cnt == TIMEOUT_LIM) begin
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                    wait_nxt    = 8'd0;
                end else begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = wait_cnt + 8'd1;
                end
            end else begin
                state_nxt = MEM_WAIT;
                wait_nxt  = 8'd1;
            end
        end else if (state != BR_SHADOW && ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            state_nxt   = BR_SHADOW;
        end else if (state != BR_SHADOW && load_use) begin
            // ID is a flushed bubble in the shadow cycle, so no load-use check there.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= mem_timeout | timeout_set;
        end
    end

    assign state_o = state;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (flush_inc && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    logic unused_cnt_inc;
    assign unused_cnt_inc = stall_inc ^ flush_inc;
    assign stall_count    = '0;
    assign flush_count    = '0;
`endif

endmodule
